// File: rtl/uart_rx_block_assembler.sv
// UART receiver (8N1, NTICKS-times oversampled) feeding a byte -> 128-bit block assembler.
// Completed blocks are presented on a valid/ready output register.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit and the par_err output.
module uart_rx_block_assembler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_AES      = 128,
  parameter int unsigned NTICKS     = 16,
  parameter int unsigned DIV_WIDTH  = 11
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 rx,
  output logic [N_AES-1:0]     blk_data,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 par_err,
`endif
  output logic [3:0]           byte_cnt
);

  localparam int unsigned BytesPerBlock = (N_AES / DATA_WIDTH) * (DATA_WIDTH / 8);
  localparam int unsigned IdxW          = $clog2(BytesPerBlock);
  localparam int unsigned TnW           = $clog2(NTICKS);
  localparam logic [TnW-1:0]  HalfLast  = TnW'(NTICKS / 2 - 1);
  localparam logic [TnW-1:0]  FullLast  = TnW'(NTICKS - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(BytesPerBlock - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e state_q, state_d;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 fall;
  logic [DIV_WIDTH-1:0] tcnt_q, tcnt_d, div_m1;
  logic                 tick, start_entry;
  logic [TnW-1:0]       tnum_q, tnum_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [N_AES-1:0]     asm_q, asm_d;
  logic [N_AES-1:0]     blk_data_q, blk_data_d;
  logic                 blk_valid_q, blk_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 byte_ok, frame_bad, block_done;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 par_err_q, par_err_d;
  logic                 par_fail;
`endif

  assign fall = rx_prev_q & ~rx_s_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Baud tick generator; >= lets a shrinking divisor wrap promptly instead of running to overflow.
  always_comb begin
    div_m1 = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
    tick   = (tcnt_q >= div_m1);
    if (start_entry || tick) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + DIV_WIDTH'(1);
    end
  end

  // Receive FSM: start-bit qualification, LSB-first data capture, stop-bit check.
  always_comb begin
    state_d     = state_q;
    tnum_d      = tnum_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    start_entry = 1'b0;
    byte_ok     = 1'b0;
    frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_fail    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d     = StStart;
          tnum_d      = '0;
          start_entry = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          if (tnum_q == HalfLast) begin
            tnum_d  = '0;
            bit_d   = '0;
            // A high line at mid start bit is a glitch, not a frame.
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            tnum_d = tnum_q + TnW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tnum_q == FullLast) begin
            tnum_d  = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            tnum_d = tnum_q + TnW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (tnum_q == FullLast) begin
            tnum_d    = '0;
            par_bad_d = rx_s_q ^ (^shift_q);
            state_d   = StStop;
          end else begin
            tnum_d = tnum_q + TnW'(1);
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (tnum_q == FullLast) begin
            tnum_d  = '0;
            state_d = StIdle;
            if (!rx_s_q) begin
              frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              par_fail = 1'b1;
`endif
            end else begin
              byte_ok = 1'b1;
            end
          end else begin
            tnum_d = tnum_q + TnW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte packing and output register handshake; a full block loads only if the register is free.
  always_comb begin
    asm_d       = asm_q;
    idx_d       = idx_q;
    blk_data_d  = blk_data_q;
    blk_valid_d = blk_valid_q & ~blk_ready;
    overrun_d   = 1'b0;
    frame_err_d = frame_bad;
    block_done  = byte_ok && (idx_q == IdxLast);
    if (byte_ok) begin
      asm_d[{idx_q, 3'b000} +: 8] = shift_q;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    if (block_done) begin
      if (!blk_valid_q || blk_ready) begin
        blk_valid_d = 1'b1;
        blk_data_d  = asm_d;
      end else begin
        overrun_d = 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
    par_err_d = par_fail;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      tcnt_q      <= '0;
      tnum_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      tnum_q      <= tnum_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign byte_cnt  = 4'(idx_q);
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_block_assembler.sv
// Directed/randomised bench for uart_rx_block_assembler with a byte-list block model.
module tb_uart_rx_block_assembler;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b1;
  logic [10:0]  divisor = 11'd2;
  logic         rx = 1'b1;
  logic         blk_ready = 1'b0;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         frame_err;
  logic         overrun;
  logic [3:0]   byte_cnt;
`ifdef UART_RX_PARITY_EN
  logic         par_err;
  logic         par_flip = 1'b0;
  int           perr_cnt = 0;
`endif

  uart_rx_block_assembler dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .divisor   (divisor),
    .rx        (rx),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .par_err   (par_err),
`endif
    .byte_cnt  (byte_cnt)
  );

  always #5 PCLK = ~PCLK;

  int passed = 0;
  int total  = 0;

  // Monitor state
  logic [127:0] got_q[$];
  int           ovr_cnt = 0, ferr_cnt = 0, fall_cnt = 0, stab_err = 0;
  logic         pv = 1'b0, pr = 1'b0;
  logic [127:0] pd = '0;

  always @(negedge PCLK) begin
    if (PRESET) begin
      pv = 1'b0;
    end else begin
      if (blk_valid && blk_ready) got_q.push_back(blk_data);
      if (overrun) ovr_cnt++;
      if (frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (par_err) perr_cnt++;
`endif
      if (pv && !blk_valid) fall_cnt++;
      if (pv && !pr && (!blk_valid || blk_data !== pd)) stab_err++;
      pv = blk_valid;
      pr = blk_ready;
      pd = blk_data;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Reference block: byte k of the stream lands in bits [8k+7:8k].
  function automatic logic [127:0] mk(input logic [7:0] b[16]);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  // Sends one frame. v_at / v_after sample blk_valid in the stop-sample cycle and the one after.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit pulse_rdy,
                           output logic v_at, output logic v_after);
    int deff, bc, off;
    deff = (divisor == 11'd0) ? 1 : int'(divisor);
    bc   = 16 * deff;
    off  = 2 + 8 * deff;
    rx = 1'b0;
    repeat (bc) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) step();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (bc) step();
`endif
    rx = stop_val;
    repeat (off) step();
    v_at = blk_valid;
    if (pulse_rdy) blk_ready = 1'b1;
    step();
    v_after = blk_valid;
    if (pulse_rdy) blk_ready = 1'b0;
    repeat (bc - off - 1) step();
  endtask

  task automatic send_block(input logic [7:0] b[16], input bit pulse_last,
                            output logic v_at, output logic v_after);
    logic va, vb;
    va = 1'b0;
    vb = 1'b0;
    for (int k = 0; k < 16; k++) send_byte(b[k], 1'b1, pulse_last && (k == 15), va, vb);
    v_at = va;
    v_after = vb;
  endtask

  logic [7:0] ba[16], bb[16], bc_[16], bd[16];
  logic       va, vb;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_valid", 128'(blk_valid), 128'd0);
    chk("rst_data", blk_data, 128'd0);
    chk("rst_cnt", 128'(byte_cnt), 128'd0);
    chk("rst_ferr", 128'(frame_err), 128'd0);
    chk("rst_ovr", 128'(overrun), 128'd0);
    PRESET = 1'b0;
    repeat (40) step();

    // Baseline: 0x00..0x0F at divisor 2, consumer always ready
    blk_ready = 1'b1;
    for (int k = 0; k < 16; k++) ba[k] = 8'(k);
    send_block(ba, 1'b0, va, vb);
    repeat (4) step();
    chk("base_lat_before", 128'(va), 128'd1 - 128'd1);
    chk("base_lat_after", 128'(vb), 128'd1);
    chk("base_count", 128'(got_q.size()), 128'd1);
    chk("base_data", got_q[0], 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("base_model", got_q[0], mk(ba));
    chk("base_cnt", 128'(byte_cnt), 128'd0);
    chk("base_valid_low", 128'(blk_valid), 128'd0);
    got_q.delete();

    // Backpressure: two blocks with no consumer, second block overruns
    blk_ready = 1'b0;
    ovr_cnt = 0;
    stab_err = 0;
    for (int k = 0; k < 16; k++) begin
      ba[k] = 8'($urandom);
      bb[k] = 8'($urandom);
    end
    send_block(ba, 1'b0, va, vb);
    chk("bp_valid1", 128'(blk_valid), 128'd1);
    chk("bp_data1", blk_data, mk(ba));
    send_block(bb, 1'b0, va, vb);
    repeat (3) step();
    chk("bp_overrun", 128'(ovr_cnt), 128'd1);
    chk("bp_data_kept", blk_data, mk(ba));
    chk("bp_cnt_wrap", 128'(byte_cnt), 128'd0);
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    repeat (3) step();
    chk("bp_xfer_count", 128'(got_q.size()), 128'd1);
    chk("bp_xfer_data", got_q[0], mk(ba));
    chk("bp_valid_drop", 128'(blk_valid), 128'd0);
    chk("bp_stable", 128'(stab_err), 128'd0);
    got_q.delete();

    // Accept of old block in the very cycle the new block completes
    ovr_cnt = 0;
    fall_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      bc_[k] = 8'($urandom);
      bd[k] = 8'($urandom);
    end
    send_block(bc_, 1'b0, va, vb);
    send_block(bd, 1'b1, va, vb);
    repeat (3) step();
    chk("sim_overrun", 128'(ovr_cnt), 128'd0);
    chk("sim_no_drop", 128'(fall_cnt), 128'd0);
    chk("sim_valid", 128'(blk_valid), 128'd1);
    chk("sim_data", blk_data, mk(bd));
    chk("sim_xfer", got_q[0], mk(bc_));
    blk_ready = 1'b1;
    repeat (3) step();
    chk("sim_drain", 128'(got_q.size()), 128'd2);
    got_q.delete();

    // Glitch and framing error
    ferr_cnt = 0;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1, 1'b0, va, vb);
    chk("pre_glitch_cnt", 128'(byte_cnt), 128'd3);
    rx = 1'b0;
    repeat (8) step();
    rx = 1'b1;
    repeat (64) step();
    chk("glitch_cnt", 128'(byte_cnt), 128'd3);
    chk("glitch_ferr", 128'(ferr_cnt), 128'd0);
    send_byte(8'hA5, 1'b0, 1'b0, va, vb);
    repeat (500) step();
    chk("ferr_pulse", 128'(ferr_cnt), 128'd1);
    chk("ferr_cnt_kept", 128'(byte_cnt), 128'd3);
    rx = 1'b1;
    repeat (64) step();
    chk("break_no_frame", 128'(byte_cnt), 128'd3);

    // Reset mid-frame after 7 bytes
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b1, 1'b0, va, vb);
    chk("seven_bytes", 128'(byte_cnt), 128'd7);
    rx = 1'b0;
    repeat (32 * 3 + 16) step();
    PRESET = 1'b1;
    rx = 1'b1;
    step();
    chk("mid_rst_cnt", 128'(byte_cnt), 128'd0);
    chk("mid_rst_data", blk_data, 128'd0);
    chk("mid_rst_valid", 128'(blk_valid), 128'd0);
    PRESET = 1'b0;
    repeat (32 * 12) step();
    for (int k = 0; k < 16; k++) ba[k] = 8'($urandom);
    send_block(ba, 1'b0, va, vb);
    repeat (3) step();
    chk("post_rst_block", got_q[0], mk(ba));
    got_q.delete();

    // divisor 0 acts as 1 (bit = 16 PCLK); exact latency confirms the tick period
    divisor = 11'd0;
    repeat (20) step();
    for (int k = 0; k < 16; k++) ba[k] = 8'($urandom);
    send_block(ba, 1'b0, va, vb);
    repeat (3) step();
    chk("div0_lat_before", 128'(va), 128'd0);
    chk("div0_lat_after", 128'(vb), 128'd1);
    chk("div0_block", got_q[0], mk(ba));
    got_q.delete();

    // Random divisor
    divisor = 11'($urandom_range(1, 3));
    repeat (20) step();
    for (int k = 0; k < 16; k++) ba[k] = 8'($urandom);
    send_block(ba, 1'b0, va, vb);
    repeat (3) step();
    chk("rdiv_lat_after", 128'(vb), 128'd1);
    chk("rdiv_block", got_q[0], mk(ba));
    got_q.delete();

`ifdef UART_RX_PARITY_EN
    perr_cnt = 0;
    par_flip = 1'b1;
    send_byte(8'h03, 1'b1, 1'b0, va, vb);
    repeat (3) step();
    chk("par_err_pulse", 128'(perr_cnt), 128'd1);
    chk("par_err_drop", 128'(byte_cnt), 128'd0);
    par_flip = 1'b0;
    send_byte(8'h03, 1'b1, 1'b0, va, vb);
    repeat (3) step();
    chk("par_ok_cnt", 128'(byte_cnt), 128'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_block_assembler.md
Name: uart_rx_block_assembler

Overview:
Downstream receive stage for the bridge's UART `tx` line: oversampling UART receiver plus a byte-to-block assembler.
- Deserialises 8N1 frames, packs bytes into 32-bit words, then packs four words into one 128-bit AES block.
- Presents each block on a valid/ready output register.
- Used as the scoreboard-side and loopback consumer of encrypted/pass-through blocks.
- Shares baud configuration (divisor, NTICKS) with the transmitter.

Parameters:
DATA_WIDTH, 32, word width; bytes per word = DATA_WIDTH/8
N_AES, 128, block width; words per block = N_AES/DATA_WIDTH
NTICKS, 16, baud ticks per bit; must be even and at least 4
DIV_WIDTH, 11, width of the divisor input

Ports:
PCLK  input  1  clock
PRESET  input  1  reset, synchronous, active-high
divisor  input  DIV_WIDTH  PCLK cycles per baud tick; 0 treated as 1
rx  input  1  serial line, idle high (connects to bridge `tx`)
blk_data  output  N_AES  assembled block
blk_valid  output  1  blk_data holds an unconsumed block
blk_ready  input  1  consumer accepts block when high with blk_valid
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed block dropped, output register occupied
byte_cnt  output  4  bytes collected toward the current block (0..15)

Behaviour:
- One clock, PCLK. Reset is synchronous and active-high on PRESET.
- Reset values:
  - all outputs 0;
  - rx synchroniser flops 1; FSM IDLE;
  - tick counter, bit counter and byte index 0;
  - assembly register 0.
- Synchroniser: rx passes through two flops; rx_s is the second-flop value. A falling edge is prev rx_s = 1 and rx_s = 0.
- Tick generator:
  - free-running counter 0..max(divisor,1)-1;
  - tick = 1 on the cycle the counter wraps;
  - the counter restarts at 0 on entry to START.
- FSM:
  - IDLE: on a falling edge of rx_s, go to START and clear the tick count.
  - START: after NTICKS/2 ticks, sample rx_s (mid start bit).
    - rx_s = 0: go to DATA.
    - rx_s = 1: false start, go to IDLE; no error is flagged.
  - DATA: every NTICKS ticks, sample one bit into the shift register, LSB first. After 8 bits, go to STOP.
  - STOP: after NTICKS ticks, sample rx_s.
    - rx_s = 1: byte accepted; go to IDLE.
    - rx_s = 0: frame_err pulses for 1 cycle, the byte is discarded, byte_cnt is unchanged; go to IDLE.
    - Because IDLE requires a falling edge, a line held low (break) does not retrigger reception.
- Assembly:
  - Accepted byte k (byte_cnt = k) is written to assembly bits [8k+7:8k].
  - Word 0 occupies [31:0]; within a word, the first byte is the LSB byte.
  - byte_cnt increments and wraps 15 -> 0 on the 16th byte.
- Block completion (16th byte accepted):
  - If the output register is free, load blk_data and set blk_valid on the next cycle. Latency from the stop-bit sample cycle is 1 PCLK.
  - Free means blk_valid = 0, or blk_valid & blk_ready in the same cycle. In the simultaneous accept-and-complete case, the new block loads and blk_valid stays 1.
  - Otherwise overrun pulses for 1 cycle and the block is dropped. blk_data keeps the old block; byte_cnt still wraps to 0.
- Handshake:
  - blk_valid holds until the cycle with blk_valid & blk_ready; it clears on the next edge unless a new block loads.
  - blk_data is stable while blk_valid = 1.
- Reset mid-frame or mid-block:
  - everything returns to reset values next edge;
  - any partial byte or partial block is lost.
- divisor changes take effect at the next tick-counter wrap. Changing divisor mid-frame is unsupported but must not hang the FSM.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - one even-parity bit follows the 8 data bits; FSM gains a PARITY state between DATA and STOP;
  - new output port par_err (1 bit, reset 0);
  - parity mismatch pulses par_err for 1 cycle at the stop sample and discards the byte;
  - frame_err takes priority if both errors occur, and only frame_err pulses.
- Undefined: no PARITY state, no par_err port; frame is 10 bits.

Test Plan:
- Baseline frame length: divisor=2, NTICKS=16, 1 bit = 32 PCLK. Send 16 bytes 0x00..0x0F back-to-back with blk_ready=1 -> one blk_valid pulse with blk_data=128'h0F0E0D0C_0B0A0908_07060504_03020100, 1 cycle after the final stop sample; byte_cnt returns to 0.
- Backpressure and overrun: hold blk_ready=0 and send 32 bytes (two blocks) -> first block held stable; overrun pulses once at the end of block 2; after blk_ready=1, one transfer and blk_valid drops.
- Simultaneous accept and complete: assert blk_ready in the exact cycle block 2 completes -> no overrun; blk_valid stays 1 with the new data.
- Glitch and framing errors:
  - 8-PCLK low glitch on idle rx -> false start, no byte, byte_cnt unchanged.
  - Frame 0xA5 with stop bit 0 -> frame_err pulse, byte_cnt unchanged; rx then held low 500 cycles -> no further frames.
- Reset and divisor edge cases:
  - Assert PRESET after 7 bytes, mid-bit of the 8th byte -> byte_cnt=0, outputs 0; the next 16 bytes form a clean block.
  - divisor=0 -> behaves as divisor=1 (bit = 16 PCLK).
- Parity (with UART_RX_PARITY_EN): 0x03 with parity 1 -> par_err pulse, byte dropped; 0x03 with parity 0 -> accepted.
